bus_initiator: RTL and testbench
================================

Name: bus_initiator

Overview:
- Single-outstanding data-bus initiator. Sits between a CPU load/store stage and the system bus, and drives the bstart/bdone protocol that memory and peripheral slaves respond to.
- Accepts one load/store request through a valid/ready handshake and issues a one-cycle bstart with the address, data, size and type held stable.
- Waits for bdone, then zero- or sign-extends read data and returns a registered response.
- Rejects misaligned accesses locally and converts slave silence into a timeout error.

Parameters:
- AW, 32, bus address width
- TIMEOUT, 16, cycles to wait for bdone after bstart before reporting an error (must be ≥2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  CPU request present
- req_ready  output  1  initiator can accept a request
- req_write  input  1  1=store, 0=load
- req_size  input  2  bus_pkg::tsize_t (BYTE/HALF/WORD)
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  AW  byte address
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_err  output  2  bus_pkg::berr_t: NONE/MISALIGN/TIMEOUT
- bus_bstart  output  1  transaction start pulse
- bus_ttype  output  1  bus_pkg::ttype_t READ/WRITE
- bus_tsize  output  2  transfer size
- bus_addr  output  AW  transfer address
- bus_wdata  output  32  store data, LSB-aligned
- bus_bdone  input  1  slave completion
- bus_rdata  input  32  slave read data, LSB-aligned, valid while bdone=1

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE. All outputs are 0, except req_ready=1 once in IDLE. Timeout counter is 0. Reset mid-transaction abandons it, and bstart is 0 from the next edge.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request fields are latched.
  - Aligned request → ISSUE.
  - Misaligned request (HALF with addr[0]=1, or WORD with addr[1:0]≠0) → RESP with resp_err=MISALIGN. No bus activity occurs.
- ISSUE:
  - bus_bstart=1 for exactly this one cycle.
  - Counter is cleared.
  - Next state is WAIT.
- WAIT:
  - bus_bstart=0. Counter increments each cycle.
  - bus_bdone=1 → latch rdata and go to RESP with err NONE.
  - Counter reaching TIMEOUT-1 without bdone → RESP with err TIMEOUT.
  - If bdone arrives in the same cycle as the timeout, bdone wins.
- RESP:
  - resp_valid=1 for one cycle. Next state is IDLE.
  - req_ready=0 here, so no back-to-back acceptance.
- bus_addr, bus_tsize, bus_ttype and bus_wdata:
  - Driven from the latched request from ISSUE through the bdone cycle inclusive.
  - Driven to 0 in IDLE and RESP.
- bus_wdata is the raw LSB-aligned req_wdata. Slaves perform lane placement.
- Load extension:
  - BYTE: rdata[7:0], extended from bit 7.
  - HALF: rdata[15:0], extended from bit 15.
  - WORD: passed through.
  - resp_rdata=0 for stores and for any error.
- Minimum latency with a 1-cycle slave, counting the accept edge as cycle 0:
  - bstart in cycle 1.
  - bdone in cycle 2.
  - resp_valid in cycle 3.
  - Next request is accepted in cycle 4.
- bdone seen in IDLE, ISSUE or RESP (a stray or late response after a timeout) is ignored and has no state effect.
- req_* inputs are sampled only at acceptance. Changes afterwards are ignored.

Decomposition:
- bus_pkg (shared with the slaves) holds:
  - ttype_t {READ, WRITE}
  - tsize_t {BYTE, HALF, WORD}
  - berr_t {NONE, MISALIGN, TIMEOUT}
  - is_aligned(addr, size) function
- Sub-module load_extend (combinational): inputs rdata, size and unsigned; output extended word. It is reused by the instruction-fetch initiator.

Test Plan:
- Word load @0x40, slave returns 0x8000_00F1 after 1 cycle → bstart pulse in cycle 1 with addr 0x40, WORD, READ. resp_valid in cycle 3 with rdata 0x8000_00F1, err NONE.
- Signed byte load @0x43, rdata=0x0000_0080 → resp_rdata 0xFFFF_FF80. Same access with req_unsigned=1 → resp_rdata 0x0000_0080.
- Half store @0x12 with wdata 0x1234_ABCD → bus_wdata 0x1234_ABCD, tsize HALF, WRITE, held stable until bdone. resp_rdata 0, err NONE.
- Word load @0x06 → no bstart ever. resp_valid 1 cycle after accept with err MISALIGN.
- Slave never asserts bdone, TIMEOUT=16 → resp_valid with err TIMEOUT 16 cycles after the bstart cycle. A later stray bdone in IDLE produces no response.
- rst asserted during WAIT → next edge is IDLE with bstart 0 and resp_valid 0. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Types and helpers shared by the bus initiators and the slaves
//               that answer the bstart/bdone protocol.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Direction of a bus transaction.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_t;

    // Transfer size. Data is always LSB-aligned on the bus.
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_t;

    // Response error code.
    typedef enum logic [1:0] {
        NONE     = 2'd0,
        MISALIGN = 2'd1,
        TIMEOUT  = 2'd2
    } berr_t;

    // Natural alignment check on the two address LSBs. The undefined size
    // encoding is held to word alignment, the strictest rule.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input tsize_t size);
        logic ok;
        case (size)
            BYTE:    ok = 1'b1;
            HALF:    ok = ~addr_lo[0];
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational zero/sign extension of LSB-aligned load data.
// Revision    : 1.0 - initial release
// Ports       : i_rdata    - raw LSB-aligned read data
//               i_size     - transfer size (bus_pkg::tsize_t)
//               i_unsigned - 1 = zero-extend, 0 = sign-extend
//               o_data     - extended 32-bit word
// ============================================================================
module load_extend
    import bus_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  tsize_t      i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic w_fill_b;
    logic w_fill_h;

    // Fill bit is the sign bit of the narrow value, or zero for unsigned loads.
    assign w_fill_b = ~i_unsigned & i_rdata[7];
    assign w_fill_h = ~i_unsigned & i_rdata[15];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            BYTE:    o_data = {{24{w_fill_b}}, i_rdata[7:0]};
            HALF:    o_data = {{16{w_fill_h}}, i_rdata[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator
// Description : Single-outstanding data-bus initiator between the CPU
//               load/store stage and the bstart/bdone system bus.
// Revision    : 1.0 - initial release
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req_*             - CPU request (valid/ready handshake)
//               resp_*            - one-cycle registered response
//               bus_bstart..wdata - transaction launch and held attributes
//               bus_bdone, rdata  - slave completion and read data
// ============================================================================
module bus_initiator #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic [1:0]    resp_err,
    output logic          bus_bstart,
    output logic          bus_ttype,
    output logic [1:0]    bus_tsize,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    input  logic          bus_bdone,
    input  logic [31:0]   bus_rdata
);

    import bus_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The counter is 0 in the first WAIT cycle; leaving WAIT when it is about
    // to reach TIMEOUT-1 puts the response TIMEOUT cycles after bstart.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 2);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_write;
    tsize_t               r_size;
    logic                 r_unsigned;
    logic [AW-1:0]        r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_resp_rdata;
    berr_t                r_resp_err;
    logic                 w_bus_act;
    logic                 w_accept;
    logic                 w_aligned;
    logic                 w_timeout;
    logic [31:0]          w_ext;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_aligned = is_aligned(req_addr[1:0], tsize_t'(req_size));
    // bdone has priority: the timeout only fires in a cycle without bdone.
    assign w_timeout = (r_state == WAIT) && !bus_bdone && (r_cnt == c_cnt_last);

    load_extend u_load_extend (
        .i_rdata    (bus_rdata),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        bus_bstart  = 1'b0;
        resp_valid  = 1'b0;
        w_bus_act   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_aligned ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                bus_bstart  = 1'b1;
                w_bus_act   = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_bus_act = 1'b1;
                if (bus_bdone || w_timeout) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timeout counter: cleared while bstart is out, counts in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Request latch and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_size       <= BYTE;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= NONE;
        end else begin
            if (w_accept) begin
                r_write      <= req_write;
                r_size       <= tsize_t'(req_size);
                r_unsigned   <= req_unsigned;
                r_addr       <= req_addr;
                r_wdata      <= req_wdata;
                r_resp_rdata <= '0;
                r_resp_err   <= w_aligned ? NONE : MISALIGN;
            end else if ((r_state == WAIT) && bus_bdone) begin
                r_resp_rdata <= r_write ? 32'd0 : w_ext;
                r_resp_err   <= NONE;
            end else if (w_timeout) begin
                r_resp_rdata <= '0;
                r_resp_err   <= bus_pkg::TIMEOUT;
            end
        end
    end

    // Bus attributes are only visible while a transaction is on the bus.
    assign bus_addr   = w_bus_act ? r_addr  : '0;
    assign bus_tsize  = w_bus_act ? r_size  : 2'b00;
    assign bus_ttype  = w_bus_act ? r_write : 1'b0;
    assign bus_wdata  = w_bus_act ? r_wdata : 32'd0;

    assign resp_rdata = resp_valid ? r_resp_rdata : 32'd0;
    assign resp_err   = resp_valid ? r_resp_err   : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_initiator
// Description : Directed self-checking bench for bus_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        bus_bstart;
    logic        bus_ttype;
    logic [1:0]  bus_tsize;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_bdone;
    logic [31:0] bus_rdata;

    int n_total = 0;
    int n_bad   = 0;

    bus_initiator #(.AW(32), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bus_bstart   (bus_bstart),
        .bus_ttype    (bus_ttype),
        .bus_tsize    (bus_tsize),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_bdone    (bus_bdone),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One aligned transaction; the slave raises bdone in the dly-th WAIT cycle.
    task automatic run_ok(input string tag, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] srd, input logic [31:0] exp_rd, input int dly);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        // Scramble the request to show it is not re-sampled.
        req_valid    = 1'b0;
        req_write    = ~wr;
        req_size     = ~sz;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = ~wd;
        check({tag, " bstart"}, {31'd0, bus_bstart}, 32'd1);
        check({tag, " addr"},   bus_addr, addr);
        check({tag, " tsize"},  {30'd0, bus_tsize}, {30'd0, sz});
        check({tag, " ttype"},  {31'd0, bus_ttype}, {31'd0, wr});
        check({tag, " wdata"},  bus_wdata, wd);
        for (int i = 0; i < dly; i++) begin
            tick();
            if (i == dly - 1) begin
                bus_bdone = 1'b1;
                bus_rdata = srd;
            end
            check({tag, " bstart low"}, {31'd0, bus_bstart}, 32'd0);
            check({tag, " addr held"},  bus_addr, addr);
            check({tag, " tsize held"}, {30'd0, bus_tsize}, {30'd0, sz});
            check({tag, " wdata held"}, bus_wdata, wd);
            check({tag, " no resp"},    {31'd0, resp_valid}, 32'd0);
        end
        tick();
        bus_bdone = 1'b0;
        bus_rdata = 32'hFFFF_FFFF;
        check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, " rdata"},      resp_rdata, exp_rd);
        check({tag, " err"},        {30'd0, resp_err}, 32'd0);
        check({tag, " addr idle"},  bus_addr, 32'd0);
        check({tag, " not ready"},  {31'd0, req_ready}, 32'd0);
        tick();
        check({tag, " resp done"},  {31'd0, resp_valid}, 32'd0);
        check({tag, " ready again"},{31'd0, req_ready}, 32'd1);
    endtask

    // Misaligned request: response one cycle after accept, no bus activity.
    task automatic run_misalign(input string tag, input logic [1:0] sz, input logic [31:0] addr);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = sz;
        req_unsigned = 1'b0;
        req_addr     = addr;
        req_wdata    = 32'h5555_5555;
        tick();
        req_valid = 1'b0;
        check({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, " err"},        {30'd0, resp_err}, 32'd1);
        check({tag, " rdata"},      resp_rdata, 32'd0);
        check({tag, " no bstart"},  {31'd0, bus_bstart}, 32'd0);
        check({tag, " no addr"},    bus_addr, 32'd0);
        tick();
        check({tag, " resp done"},  {31'd0, resp_valid}, 32'd0);
        check({tag, " no bstart2"}, {31'd0, bus_bstart}, 32'd0);
        check({tag, " ready"},      {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        bus_bdone    = 1'b0;
        bus_rdata    = 32'd0;
        tick();
        tick();
        check("rst ready",  {31'd0, req_ready}, 32'd1);
        check("rst resp",   {31'd0, resp_valid}, 32'd0);
        check("rst bstart", {31'd0, bus_bstart}, 32'd0);
        check("rst addr",   bus_addr, 32'd0);
        check("rst rdata",  resp_rdata, 32'd0);
        rst = 1'b0;
        tick();

        run_ok("wload",   1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'h8000_00F1, 32'h8000_00F1, 1);
        run_ok("sbyte",   1'b0, 2'd0, 1'b0, 32'h0000_0043, 32'h0, 32'h0000_0080, 32'hFFFF_FF80, 1);
        run_ok("ubyte",   1'b0, 2'd0, 1'b1, 32'h0000_0043, 32'h0, 32'h0000_0080, 32'h0000_0080, 1);
        run_ok("hstore",  1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h1234_ABCD, 32'hDEAD_BEEF, 32'h0, 3);
        run_ok("shalf",   1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0, 32'h1234_8001, 32'hFFFF_8001, 2);
        run_ok("uhalf",   1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 32'h1234_8001, 32'h0000_8001, 1);

        run_misalign("mis word", 2'd2, 32'h0000_0006);
        run_misalign("mis half", 2'd1, 32'h0000_0101);

        // Silent slave: response 16 cycles after the bstart cycle.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0100;
        tick();
        req_valid = 1'b0;
        check("to bstart", {31'd0, bus_bstart}, 32'd1);
        for (int c = 2; c <= 16; c++) begin
            tick();
            check("to early resp", {31'd0, resp_valid}, 32'd0);
        end
        tick();
        check("to resp_valid", {31'd0, resp_valid}, 32'd1);
        check("to err",        {30'd0, resp_err}, 32'd2);
        check("to rdata",      resp_rdata, 32'd0);
        tick();
        // Late bdone in IDLE must be ignored.
        bus_bdone = 1'b1;
        bus_rdata = 32'h1111_2222;
        tick();
        bus_bdone = 1'b0;
        check("stray resp",   {31'd0, resp_valid}, 32'd0);
        check("stray bstart", {31'd0, bus_bstart}, 32'd0);
        check("stray ready",  {31'd0, req_ready}, 32'd1);
        tick();
        check("stray resp2",  {31'd0, resp_valid}, 32'd0);

        // Reset while waiting for bdone.
        req_valid = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0200;
        tick();
        req_valid = 1'b0;
        tick();
        check("rw in wait", {31'd0, bus_bstart}, 32'd0);
        check("rw addr",    bus_addr, 32'h0000_0200);
        rst = 1'b1;
        tick();
        check("rw bstart",  {31'd0, bus_bstart}, 32'd0);
        check("rw resp",    {31'd0, resp_valid}, 32'd0);
        check("rw ready",   {31'd0, req_ready}, 32'd1);
        check("rw addr0",   bus_addr, 32'd0);
        rst = 1'b0;
        tick();
        check("rw idle resp", {31'd0, resp_valid}, 32'd0);
        run_ok("post rst", 1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
